// File: rtl/vpu_pkg.sv
// Shared definitions for the vector unit: opcode encodings, FSM states, opcode helpers.
// Pure declarations; no timing or flow control of its own.
package vpu_pkg;

   localparam logic [6:0] VADD = 7'h00;
   localparam logic [6:0] VSUB = 7'h01;
   localparam logic [6:0] VMUL = 7'h02;
   localparam logic [6:0] VAND = 7'h03;
   localparam logic [6:0] VOR  = 7'h04;
   localparam logic [6:0] VXOR = 7'h05;
   localparam logic [6:0] VLD  = 7'h10;
   localparam logic [6:0] VST  = 7'h11;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ALU,
      S_MEM,
      S_DONE
   } state_t;

   function automatic logic is_mem_op(input logic [6:0] f);
      return (f == VLD) || (f == VST);
   endfunction

   function automatic logic is_legal_op(input logic [6:0] f);
      return (f <= VXOR) || is_mem_op(f);
   endfunction

endpackage

// File: rtl/vpu_lane.sv
// Single-element ALU, purely combinational (zero latency, no flow control).
// Memory and illegal opcodes produce 0; the top never writes their result.
module vpu_lane
   import vpu_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [6:0]            funct,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   output logic [DATA_WIDTH-1:0] y
);

   always_comb begin
      y = '0;
      case (funct)
         VADD:    y = a + b;
         VSUB:    y = a - b;
         VMUL:    y = a * b;
         VAND:    y = a & b;
         VOR:     y = a | b;
         VXOR:    y = a ^ b;
         default: y = '0;
      endcase
   end

endmodule

// File: rtl/vector_proc_v4.sv
// Vector unit: NUM_LANES-wide ALU (done at accept+G+1) and strided load/store, one bus transfer per ack.
// Issue is a strobe accepted only in IDLE; bus requests hold address/data stable until acked.
module vector_proc_v4
   import vpu_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int VLEN          = 8,
   parameter int NUM_LANES     = 4,
   parameter int NUM_REGISTERS = 32
) (
`ifdef USE_POWER_PINS
   inout  wire                                 vccd1,
   inout  wire                                 vssd1,
`endif
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                start_op,
   input  logic [6:0]                          funct,
   input  logic                                vm,
   input  logic [$clog2(NUM_REGISTERS)-1:0]    vs1,
   input  logic [$clog2(NUM_REGISTERS)-1:0]    vs2,
   input  logic [$clog2(NUM_REGISTERS)-1:0]    vd,
   input  logic [31:0]                         vl,
   input  logic [31:0]                         mem_base,
   input  logic [31:0]                         mem_stride,
   output logic                                op_busy,
   output logic                                op_done,
   output logic                                op_err,
   output logic                                mem_req,
   output logic                                mem_we,
   output logic [31:0]                         mem_addr,
   output logic [DATA_WIDTH-1:0]               mem_wdata,
   input  logic [DATA_WIDTH-1:0]               mem_rdata,
   input  logic                                mem_ack
);

   localparam int RW = $clog2(NUM_REGISTERS);
   localparam int IW = $clog2(VLEN);
   localparam int EW = $clog2(VLEN + 1);

   typedef struct packed {
      logic [6:0]    funct;
      logic          vm;
      logic          err;
      logic [RW-1:0] vs1;
      logic [RW-1:0] vs2;
      logic [RW-1:0] vd;
      logic [EW-1:0] evl;
      logic [31:0]   base;
      logic [31:0]   stride;
   } op_t;

   state_t                state, state_nxt;
   op_t                   op;
   logic [VLEN-1:0]       mask, act, v0_bits;
   logic [EW-1:0]         pos, evl_in;
   logic [IW-1:0]         cur;
   logic                  found, alu_last, xfer;
   logic [DATA_WIDTH-1:0] rf [NUM_REGISTERS][VLEN];
   logic [VLEN-1:0]       el_we;
   logic [DATA_WIDTH-1:0] el_wd [VLEN];
   logic [IW-1:0]         lane_idx [NUM_LANES];
   logic [DATA_WIDTH-1:0] lane_a [NUM_LANES];
   logic [DATA_WIDTH-1:0] lane_b [NUM_LANES];
   logic [DATA_WIDTH-1:0] lane_y [NUM_LANES];

   always_comb begin
      evl_in = (vl > 32'(VLEN)) ? EW'(VLEN) : vl[EW-1:0];
      for (int i = 0; i < VLEN; i++) v0_bits[i] = rf[0][i][0];
   end

   // Active elements: inside evl and, for masked ops, enabled by the mask captured at accept.
   always_comb begin
      act = '0;
      for (int i = 0; i < VLEN; i++) act[i] = (EW'(i) < op.evl) && (!op.vm || mask[i]);
   end

   // Lowest active element at or above pos; masked-off elements are skipped without a bus cycle.
   always_comb begin
      found = 1'b0;
      cur   = '0;
      for (int i = VLEN - 1; i >= 0; i--) begin
         if (act[i] && (EW'(i) >= pos)) begin
            found = 1'b1;
            cur   = IW'(i);
         end
      end
   end

   always_comb begin
      for (int l = 0; l < NUM_LANES; l++) begin
         lane_idx[l] = pos[IW-1:0] + IW'(l);
         lane_a[l]   = rf[op.vs1][lane_idx[l]];
         lane_b[l]   = rf[op.vs2][lane_idx[l]];
      end
   end

   for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
      vpu_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
         .funct (op.funct),
         .a     (lane_a[l]),
         .b     (lane_b[l]),
         .y     (lane_y[l])
      );
   end

   assign alu_last = (pos + EW'(NUM_LANES)) >= op.evl;
   assign xfer     = mem_req && mem_ack;

   always_comb begin
      el_we = '0;
      for (int i = 0; i < VLEN; i++) el_wd[i] = '0;
      if (state == S_ALU) begin
         for (int l = 0; l < NUM_LANES; l++) begin
            if (act[lane_idx[l]]) begin
               el_we[lane_idx[l]] = 1'b1;
               el_wd[lane_idx[l]] = lane_y[l];
            end
         end
      end else if (xfer && (op.funct == VLD)) begin
         el_we[cur] = 1'b1;
         el_wd[cur] = mem_rdata;
      end
   end

   for (genvar r = 0; r < NUM_REGISTERS; r++) begin : g_reg
      for (genvar e = 0; e < VLEN; e++) begin : g_el
         logic [DATA_WIDTH-1:0] q;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)                          q <= '0;
            else if (el_we[e] && (op.vd == RW'(r))) q <= el_wd[e];
         end
         assign rf[r][e] = q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      op_busy   = (state != S_IDLE);
      op_done   = (state == S_DONE);
      op_err    = (state == S_DONE) && op.err;
      mem_req   = (state == S_MEM) && found;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (mem_req) begin
         mem_we   = (op.funct == VST);
         mem_addr = op.base + (32'(cur) * op.stride);
         if (mem_we) mem_wdata = rf[op.vs2][cur];
      end
      case (state)
         S_IDLE: if (start_op) state_nxt = is_mem_op(funct) ? S_MEM : S_ALU;
         S_ALU:  if (alu_last) state_nxt = S_DONE;
         S_MEM:  if (!found)   state_nxt = S_DONE;
         S_DONE: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Illegal opcodes ride the ALU path with evl forced to 0, so they write nothing.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op   <= '0;
         mask <= '0;
         pos  <= '0;
      end else begin
         case (state)
            S_IDLE: if (start_op) begin
               op.funct  <= funct;
               op.vm     <= vm;
               op.err    <= !is_legal_op(funct);
               op.vs1    <= vs1;
               op.vs2    <= vs2;
               op.vd     <= vd;
               op.evl    <= is_legal_op(funct) ? evl_in : '0;
               op.base   <= mem_base;
               op.stride <= mem_stride;
               mask      <= v0_bits;
               pos       <= '0;
            end
            S_ALU: pos <= pos + EW'(NUM_LANES);
            S_MEM: if (xfer) pos <= EW'(cur) + EW'(1);
            default: ;
         endcase
      end
   end

endmodule
